// File: rtl/stream_demux.sv
// stream_demux: routes one valid/ready stream into NOUT single-entry output slots selected by in_sel.
// Broadcast mode (in_bcast port) is compiled in only when STREAM_DEMUX_BROADCAST_EN is defined.
module stream_demux #(
    parameter int WIDTH = 64,
    parameter int NOUT  = 4,
    parameter int SELW  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [SELW-1:0]       in_sel,
    input  logic                  in_valid,
`ifdef STREAM_DEMUX_BROADCAST_EN
    input  logic                  in_bcast,
`endif
    output logic                  in_ready,
    output logic [NOUT*WIDTH-1:0] out_data,
    output logic [NOUT-1:0]       out_valid,
    input  logic [NOUT-1:0]       out_ready,
    output logic [15:0]           drop_cnt
);

    logic [NOUT-1:0]  w_free;
    logic [NOUT-1:0]  w_hit;
    logic [NOUT-1:0]  w_load;
    logic             w_in_range;
    logic             w_sel_free;
    logic             w_route_ready;
    logic             w_xfer;
    logic             w_drop;
    logic             r_valid [NOUT];
    logic [WIDTH-1:0] r_data  [NOUT];
    logic [15:0]      r_drop;

    genvar gi;
    generate
        for (gi = 0; gi < NOUT; gi++) begin : g_slot
            assign w_free[gi] = !r_valid[gi] || out_ready[gi];
            assign w_hit[gi]  = (in_sel == SELW'(gi));
`ifdef STREAM_DEMUX_BROADCAST_EN
            assign w_load[gi] = w_xfer && (in_bcast || w_hit[gi]);
`else
            assign w_load[gi] = w_xfer && w_hit[gi];
`endif

            // A refill wins over a drain so a slot can pass one word per cycle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid[gi] <= 1'b0;
                    r_data[gi]  <= '0;
                end else if (w_load[gi]) begin
                    r_valid[gi] <= 1'b1;
                    r_data[gi]  <= in_data;
                end else if (r_valid[gi] && out_ready[gi]) begin
                    r_valid[gi] <= 1'b0;
                    r_data[gi]  <= '0;
                end
            end

            assign out_valid[gi]               = r_valid[gi];
            assign out_data[gi*WIDTH +: WIDTH] = r_data[gi];
        end
    endgenerate

    // Out-of-range selects are always accepted and then discarded.
    assign w_in_range    = |w_hit;
    assign w_sel_free    = |(w_hit & w_free);
    assign w_route_ready = w_in_range ? w_sel_free : 1'b1;

`ifdef STREAM_DEMUX_BROADCAST_EN
    assign in_ready = !rst && (in_bcast ? (&w_free) : w_route_ready);
    assign w_drop   = w_xfer && !in_bcast && !w_in_range;
`else
    assign in_ready = !rst && w_route_ready;
    assign w_drop   = w_xfer && !w_in_range;
`endif

    assign w_xfer = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop <= 16'd0;
        end else if (w_drop && (r_drop != 16'hFFFF)) begin
            r_drop <= r_drop + 16'd1;
        end
    end

    assign drop_cnt = r_drop;

endmodule
